// File: rtl/knight_cmd_sequencer.sv
// Bench-side command sequencer: issues up to NUM_CMDS commands to RemoteComm and checks each response.
// Optional macro KCS_RETRY_EN: a NAKed command is re-issued once before the sequence fails.
module knight_cmd_sequencer #(
    parameter int unsigned NUM_CMDS = 8,
    parameter int unsigned TMO_W    = 24,
    parameter int unsigned TMO_CLKS = 1000000,
    parameter logic [7:0]  POS_ACK  = 8'hA5
) (
    input  logic                              clk,
    input  logic                              RST_n,
    input  logic                              start,
    input  logic [$clog2(NUM_CMDS+1)-1:0]     num_cmds,
    input  logic [16*NUM_CMDS-1:0]            cmd_list,
    output logic [15:0]                       cmd,
    output logic                              snd_cmd,
    input  logic                              cmd_snt,
    input  logic                              resp_rdy,
    input  logic [7:0]                        resp,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              err_tmo,
    output logic                              err_nak,
    output logic [$clog2(NUM_CMDS+1)-1:0]     cmd_idx
);

    localparam int unsigned      IW       = $clog2(NUM_CMDS + 1);
    localparam logic [IW-1:0]    MAX_IDX  = IW'(NUM_CMDS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     n_q, n_d;
    logic [IW-1:0]     cmd_idx_q, cmd_idx_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              snd_cmd_q, snd_cmd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              err_tmo_q, err_tmo_d;
    logic              err_nak_q, err_nak_d;
    logic [15:0]       cmd_sel;
    logic              got_resp;
`ifdef KCS_RETRY_EN
    logic              retry_q, retry_d;
`endif

    always_comb begin
        cmd_sel = '0;
        for (int unsigned i = 0; i < NUM_CMDS; i++) begin
            if (cmd_idx_q == IW'(i)) begin
                cmd_sel = cmd_list[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cmd_idx_d = cmd_idx_q;
        cmd_d     = cmd_q;
        tmo_d     = tmo_q;
        pass_d    = pass_q;
        err_tmo_d = err_tmo_q;
        err_nak_d = err_nak_q;
        got_resp  = 1'b0;
`ifdef KCS_RETRY_EN
        retry_d   = retry_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d       = (num_cmds > MAX_IDX) ? MAX_IDX : num_cmds;
                    cmd_idx_d = '0;
                    pass_d    = 1'b0;
                    err_tmo_d = 1'b0;
                    err_nak_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
`ifdef KCS_RETRY_EN
                retry_d = 1'b0;
`endif
                if (cmd_idx_q == n_q) begin
                    state_d = FINISH;
                end else begin
                    cmd_d   = cmd_sel;
                    state_d = SEND;
                end
            end
            SEND: begin
                tmo_d   = '0;
                state_d = WAIT_SNT;
            end
            WAIT_SNT, WAIT_RESP: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A response arriving together with cmd_snt is handled as if already in WAIT_RESP.
                got_resp = resp_rdy && ((state_q == WAIT_RESP) || cmd_snt);
                if (got_resp) begin
                    if (resp == POS_ACK) begin
                        if (cmd_idx_q < n_q) begin
                            cmd_idx_d = cmd_idx_q + IW'(1);
                        end
                        state_d = LOAD;
                    end else begin
`ifdef KCS_RETRY_EN
                        if (!retry_q) begin
                            retry_d = 1'b1;
                            state_d = SEND;
                        end else begin
                            err_nak_d = 1'b1;
                            state_d   = FINISH;
                        end
`else
                        err_nak_d = 1'b1;
                        state_d   = FINISH;
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    state_d   = FINISH;
                end else if ((state_q == WAIT_SNT) && cmd_snt) begin
                    state_d = WAIT_RESP;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // FINISH is always left after one clock, so this fires only on entry.
        if (state_d == FINISH) begin
            pass_d = !err_tmo_d && !err_nak_d;
        end

        snd_cmd_d = (state_d == SEND);
        done_d    = (state_d == FINISH);
        busy_d    = (state_d == LOAD) || (state_d == SEND) ||
                    (state_d == WAIT_SNT) || (state_d == WAIT_RESP);
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cmd_idx_q <= '0;
            cmd_q     <= '0;
            tmo_q     <= '0;
            snd_cmd_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_tmo_q <= 1'b0;
            err_nak_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cmd_idx_q <= cmd_idx_d;
            cmd_q     <= cmd_d;
            tmo_q     <= tmo_d;
            snd_cmd_q <= snd_cmd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_tmo_q <= err_tmo_d;
            err_nak_q <= err_nak_d;
        end
    end

`ifdef KCS_RETRY_EN
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            retry_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign cmd     = cmd_q;
    assign snd_cmd = snd_cmd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_tmo = err_tmo_q;
    assign err_nak = err_nak_q;
    assign cmd_idx = cmd_idx_q;

endmodule

// File: tb/tb_knight_cmd_sequencer.sv
// Scoreboard bench for knight_cmd_sequencer: stimulus queues expected commands/results, a monitor checks them.
module tb_knight_cmd_sequencer;

    localparam int unsigned NC  = 8;
    localparam int unsigned TMO = 100;

    logic              clk      = 1'b0;
    logic              RST_n    = 1'b1;
    logic              start    = 1'b0;
    logic [3:0]        num_cmds = '0;
    logic [16*NC-1:0]  cmd_list = '0;
    logic [15:0]       cmd;
    logic              snd_cmd;
    logic              cmd_snt  = 1'b0;
    logic              resp_rdy = 1'b0;
    logic [7:0]        resp     = '0;
    logic              busy, done, pass, err_tmo, err_nak;
    logic [3:0]        cmd_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] cmd;
        int          cyc;
    } exp_cmd_t;

    typedef struct {
        logic        p;
        logic        et;
        logic        en;
        logic [3:0]  idx;
        int          cyc;
    } exp_done_t;

    exp_cmd_t  cq[$];
    exp_done_t dq[$];

    knight_cmd_sequencer #(
        .NUM_CMDS(NC),
        .TMO_W(24),
        .TMO_CLKS(TMO),
        .POS_ACK(8'hA5)
    ) dut (
        .clk(clk),
        .RST_n(RST_n),
        .start(start),
        .num_cmds(num_cmds),
        .cmd_list(cmd_list),
        .cmd(cmd),
        .snd_cmd(snd_cmd),
        .cmd_snt(cmd_snt),
        .resp_rdy(resp_rdy),
        .resp(resp),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_tmo(err_tmo),
        .err_nak(err_nak),
        .cmd_idx(cmd_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_cmd(input logic [15:0] c, input int at);
        exp_cmd_t e;
        e.cmd = c;
        e.cyc = at;
        cq.push_back(e);
    endtask

    task automatic push_done(input logic p, input logic et, input logic en, input logic [3:0] idx, input int at);
        exp_done_t e;
        e.p   = p;
        e.et  = et;
        e.en  = en;
        e.idx = idx;
        e.cyc = at;
        dq.push_back(e);
    endtask

    // Monitor: compare every snd_cmd / done pulse against the front of its queue.
    exp_cmd_t    ec;
    exp_done_t   ed;
    logic [15:0] cur_cmd = '0;
    bit          holding = 1'b0;
    bit          hold_bad = 1'b0;

    always @(negedge clk) begin
        if (RST_n) begin
            if (snd_cmd) begin
                if (cq.size() == 0) begin
                    check("unexpected_snd_cmd", snd_cmd, 0);
                end else begin
                    ec = cq.pop_front();
                    check("cmd_value", cmd, ec.cmd);
                    check("snd_cycle", cyc, ec.cyc);
                    check("busy_at_snd", busy, 1);
                    cur_cmd  = ec.cmd;
                    holding  = 1'b1;
                    hold_bad = 1'b0;
                end
            end else if (holding) begin
                if (cmd !== cur_cmd) hold_bad = 1'b1;
                if (cmd_snt) begin
                    check("cmd_hold", hold_bad, 0);
                    holding = 1'b0;
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    ed = dq.pop_front();
                    check("done_cycle", cyc, ed.cyc);
                    check("done_pass", pass, ed.p);
                    check("done_err_tmo", err_tmo, ed.et);
                    check("done_err_nak", err_nak, ed.en);
                    check("done_cmd_idx", cmd_idx, ed.idx);
                    check("done_busy", busy, 0);
                end
            end
        end else begin
            holding = 1'b0;
        end
    end

    task automatic set_cmd(input int i, input logic [15:0] v);
        cmd_list[16*i +: 16] = v;
    endtask

    task automatic do_start(input logic [3:0] n, input int n_eff, output int t0);
        logic [15:0] first;
        @(posedge clk); #1;
        start    = 1'b1;
        num_cmds = n;
        t0       = cyc;
        first    = cmd_list[15:0];
        if (n_eff > 0) push_cmd(first, t0 + 2);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // RemoteComm model: wait for snd_cmd, return cmd_snt after snt_dly clks, response rsp_dly clks later.
    task automatic serve(input logic [7:0] rb, input int snt_dly, input int rsp_dly, input bit give,
                         output int s, output int r);
        int n;
        n = 0;
        r = -1;
        @(negedge clk);
        while (!snd_cmd && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("snd_cmd_seen", snd_cmd, 1);
        s = cyc;
        repeat (snt_dly) begin @(posedge clk); #1; end
        cmd_snt = 1'b1;
        if (give && rsp_dly == 0) begin
            resp_rdy = 1'b1;
            resp     = rb;
            r        = cyc;
        end
        @(posedge clk); #1;
        cmd_snt  = 1'b0;
        resp_rdy = 1'b0;
        if (give && rsp_dly > 0) begin
            repeat (rsp_dly - 1) begin @(posedge clk); #1; end
            resp_rdy = 1'b1;
            resp     = rb;
            r        = cyc;
            @(posedge clk); #1;
            resp_rdy = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((cq.size() != 0 || dq.size() != 0) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain", cq.size() + dq.size(), 0);
        cq.delete();
        dq.delete();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic run_ack(input logic [3:0] n, input int n_eff);
        int t0, s, r;
        logic [15:0] nxt;
        do_start(n, n_eff, t0);
        if (n_eff == 0) push_done(1'b1, 1'b0, 1'b0, 4'd0, t0 + 2);
        for (int i = 0; i < n_eff; i++) begin
            serve(8'hA5, 1 + (i % 3), (i % 2) ? 0 : 2, 1'b1, s, r);
            if (i + 1 < n_eff) begin
                nxt = cmd_list[16*(i+1) +: 16];
                push_cmd(nxt, r + 2);
            end else begin
                push_done(1'b1, 1'b0, 1'b0, 4'(n_eff), r + 2);
            end
        end
        wait_idle(300);
    endtask

    initial begin
        int t0, s, r;

        #1 RST_n = 1'b0;
        #2;
        check("rst_cmd", cmd, 0);
        check("rst_snd_cmd", snd_cmd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_tmo", err_tmo, 0);
        check("rst_err_nak", err_nak, 0);
        check("rst_cmd_idx", cmd_idx, 0);
        repeat (2) @(posedge clk);
        #1 RST_n = 1'b1;

        // Stray NAK while idle must be ignored.
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        resp     = 8'h5A;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("stray_resp_err_nak", err_nak, 0);
        check("stray_resp_busy", busy, 0);

        // Single CAL_GYRO, then a three-command list.
        set_cmd(0, 16'h2000);
        run_ack(4'd1, 1);
        set_cmd(1, 16'h4BF1);
        set_cmd(2, 16'h2BF1);
        run_ack(4'd3, 3);

        // NAK on the second command.
        do_start(4'd2, 2, t0);
        serve(8'hA5, 2, 1, 1'b1, s, r);
        push_cmd(16'h4BF1, r + 2);
        serve(8'h5A, 1, 3, 1'b1, s, r);
`ifdef KCS_RETRY_EN
        push_cmd(16'h4BF1, r + 1);
        serve(8'h5A, 1, 1, 1'b1, s, r);
`endif
        push_done(1'b0, 1'b0, 1'b1, 4'd1, r + 1);
        wait_idle(300);

        // Timeout on the second command: cmd_snt arrives but no response.
        do_start(4'd2, 2, t0);
        serve(8'hA5, 1, 2, 1'b1, s, r);
        push_cmd(16'h4BF1, r + 2);
        serve(8'h00, 2, 0, 1'b0, s, r);
        push_done(1'b0, 1'b1, 1'b0, 4'd1, s + 100);
        wait_idle(300);

        // Response on the terminal-count clock is accepted.
        do_start(4'd1, 1, t0);
        serve(8'hA5, 1, 98, 1'b1, s, r);
        push_done(1'b1, 1'b0, 1'b0, 4'd1, s + 101);
        wait_idle(300);

        // Empty list, then an oversize count that clamps to eight.
        run_ack(4'd0, 0);
        for (int i = 0; i < 8; i++) set_cmd(i, 16'h1000 + 16'(i));
        run_ack(4'd15, 8);

        // Reset while waiting for a response.
        set_cmd(0, 16'h4BF1);
        do_start(4'd1, 1, t0);
        serve(8'h00, 1, 0, 1'b0, s, r);
        check("busy_before_rst", busy, 1);
        #1 RST_n = 1'b0;
        #1;
        check("midrst_cmd", cmd, 0);
        check("midrst_busy", busy, 0);
        check("midrst_snd_cmd", snd_cmd, 0);
        check("midrst_done", done, 0);
        check("midrst_flags", {pass, err_tmo, err_nak}, 0);
        check("midrst_cmd_idx", cmd_idx, 0);
        repeat (2) @(posedge clk);
        #1 RST_n = 1'b1;
        cq.delete();
        dq.delete();
        set_cmd(0, 16'h2000);
        run_ack(4'd1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
